// File: rtl/stepper_seq_ctrl.sv
// Unipolar stepper sequencer: full/wave/half drive, programmable step period, bounded or continuous moves.
// Outputs are registered from next-state; hold freezes the step divider, stop aborts a run.
module stepper_seq_ctrl #(
   parameter int DIV_W   = 16,
   parameter int CNT_W   = 16,
   parameter int POS_W   = 16,
   parameter bit HOLD_EN = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [CNT_W-1:0] steps_n,
   input  logic             dir,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] period,
   input  logic             hold,
   input  logic             stop,
   output logic [3:0]       coil,
   output logic             busy,
   output logic             done,
   output logic [POS_W-1:0] position,
   output logic [3:0]       ledsR,
   output logic [3:0]       ledsG
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

   state_t           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic             dir_q, dir_d;
   logic [1:0]       mode_q, mode_d;
   logic [DIV_W-1:0] period_q, period_d;
   logic             energ_q, energ_d;
   logic [3:0]       coil_q, coil_d;
   logic [3:0]       ledsr_q, ledsr_d;
   logic [3:0]       ledsg_q, ledsg_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [2:0]       delta;
   logic [2:0]       idx_step;
   logic             drive;

   function automatic logic [3:0] phase(input logic [2:0] i);
      logic [3:0] p;
      case (i)
         3'd0:    p = 4'b0110;
         3'd1:    p = 4'b0100;
         3'd2:    p = 4'b0101;
         3'd3:    p = 4'b0001;
         3'd4:    p = 4'b1001;
         3'd5:    p = 4'b1000;
         3'd6:    p = 4'b1010;
         default: p = 4'b0010;
      endcase
      return p;
   endfunction

   // Even indices are the full-step set, odd the wave set; a 1-step jump re-aligns to the mode's set.
   always_comb begin
      case (mode_q)
         2'b10:   delta = 3'd1;
         2'b01:   delta = idx_q[0] ? 3'd2 : 3'd1;
         default: delta = idx_q[0] ? 3'd1 : 3'd2;
      endcase
      idx_step = dir_q ? (idx_q + delta) : (idx_q - delta);
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      div_d    = div_q;
      rem_d    = rem_q;
      pos_d    = pos_q;
      dir_d    = dir_q;
      mode_d   = mode_q;
      period_d = period_q;
      energ_d  = energ_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_RUN;
               dir_d    = dir;
               mode_d   = mode;
               period_d = period;
               rem_d    = steps_n;
               div_d    = '0;
               energ_d  = 1'b1;
            end
         end
         S_RUN: begin
            if (stop) begin
               state_d = S_DONE;
            end else if (!hold) begin
               if (div_q == period_q) begin
                  div_d = '0;
                  idx_d = idx_step;
                  pos_d = dir_q ? (pos_q + POS_ONE) : (pos_q - POS_ONE);
                  // rem of zero while running marks a continuous move
                  if (rem_q != '0) begin
                     rem_d = rem_q - CNT_ONE;
                     if (rem_q == CNT_ONE) state_d = S_DONE;
                  end
               end else begin
                  div_d = div_q + DIV_ONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Coils stay de-energised after reset until the first move, even with hold enabled.
      drive   = (state_d == S_RUN) || (HOLD_EN && energ_d);
      coil_d  = drive ? phase(idx_d) : 4'b0000;
      ledsr_d = dir_d ? coil_d : 4'b0000;
      ledsg_d = dir_d ? 4'b0000 : coil_d;
      busy_d  = (state_d == S_RUN);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         div_q    <= '0;
         rem_q    <= '0;
         pos_q    <= '0;
         dir_q    <= 1'b0;
         mode_q   <= 2'b00;
         period_q <= '0;
         energ_q  <= 1'b0;
         coil_q   <= 4'b0000;
         ledsr_q  <= 4'b0000;
         ledsg_q  <= 4'b0000;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         div_q    <= div_d;
         rem_q    <= rem_d;
         pos_q    <= pos_d;
         dir_q    <= dir_d;
         mode_q   <= mode_d;
         period_q <= period_d;
         energ_q  <= energ_d;
         coil_q   <= coil_d;
         ledsr_q  <= ledsr_d;
         ledsg_q  <= ledsg_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign coil     = coil_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign position = pos_q;
   assign ledsR    = ledsr_q;
   assign ledsG    = ledsg_q;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
// Directed bench for stepper_seq_ctrl: one hold-enabled 16-bit-position instance, one
// hold-disabled 4-bit-position instance, checked with immediate assertions.
module tb_stepper_seq_ctrl;

   logic clk;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // instance A: HOLD_EN=1, POS_W=16
   logic        a_rst_n, a_start, a_dir, a_hold, a_stop;
   logic [15:0] a_steps, a_period;
   logic [1:0]  a_mode;
   logic [3:0]  a_coil, a_ledsR, a_ledsG;
   logic        a_busy, a_done;
   logic [15:0] a_pos;

   // instance B: HOLD_EN=0, POS_W=4
   logic        b_rst_n, b_start, b_dir, b_hold, b_stop;
   logic [15:0] b_steps, b_period;
   logic [1:0]  b_mode;
   logic [3:0]  b_coil, b_ledsR, b_ledsG;
   logic        b_busy, b_done;
   logic [3:0]  b_pos;

   stepper_seq_ctrl #(.DIV_W(16), .CNT_W(16), .POS_W(16), .HOLD_EN(1'b1)) u_a (
      .clk(clk), .rst_n(a_rst_n), .start(a_start), .steps_n(a_steps), .dir(a_dir),
      .mode(a_mode), .period(a_period), .hold(a_hold), .stop(a_stop),
      .coil(a_coil), .busy(a_busy), .done(a_done), .position(a_pos),
      .ledsR(a_ledsR), .ledsG(a_ledsG)
   );

   stepper_seq_ctrl #(.DIV_W(16), .CNT_W(16), .POS_W(4), .HOLD_EN(1'b0)) u_b (
      .clk(clk), .rst_n(b_rst_n), .start(b_start), .steps_n(b_steps), .dir(b_dir),
      .mode(b_mode), .period(b_period), .hold(b_hold), .stop(b_stop),
      .coil(b_coil), .busy(b_busy), .done(b_done), .position(b_pos),
      .ledsR(b_ledsR), .ledsG(b_ledsG)
   );

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [3:0] full_exp [4];
   logic [3:0] prev;

   initial begin
      full_exp[0] = 4'b0101; full_exp[1] = 4'b1001;
      full_exp[2] = 4'b1010; full_exp[3] = 4'b0110;

      a_rst_n = 1'b0; a_start = 1'b0; a_dir = 1'b0; a_hold = 1'b0; a_stop = 1'b0;
      a_steps = '0; a_period = '0; a_mode = 2'b00;
      b_rst_n = 1'b0; b_start = 1'b0; b_dir = 1'b0; b_hold = 1'b0; b_stop = 1'b0;
      b_steps = '0; b_period = '0; b_mode = 2'b00;

      #2;
      chk4 ("rst_coil",  a_coil, 4'b0000);
      chk1 ("rst_busy",  a_busy, 1'b0);
      chk1 ("rst_done",  a_done, 1'b0);
      chk16("rst_pos",   a_pos, 16'h0000);
      chk4 ("rst_ledsR", a_ledsR, 4'b0000);
      chk4 ("rst_ledsG", a_ledsG, 4'b0000);
      chk4 ("rst_b_coil", b_coil, 4'b0000);
      tick;
      a_rst_n = 1'b1; b_rst_n = 1'b1;
      tick;

      // full step forward, 4 steps, period 3
      a_start = 1'b1; a_steps = 16'd4; a_dir = 1'b1; a_mode = 2'b00; a_period = 16'd3;
      tick;
      a_start = 1'b0;
      chk1("full_busy_start", a_busy, 1'b1);
      chk4("full_coil_start", a_coil, 4'b0110);
      chk1("full_done_start", a_done, 1'b0);
      prev = 4'b0110;
      for (int k = 0; k < 4; k++) begin
         repeat (3) tick;
         chk4("full_coil_pre", a_coil, prev);
         tick;
         chk4 ("full_coil_step", a_coil, full_exp[k]);
         chk16("full_pos_step", a_pos, 16'(k + 1));
         prev = full_exp[k];
      end
      chk1("full_done", a_done, 1'b1);
      chk1("full_busy_end", a_busy, 1'b0);
      chk4("full_ledsR", a_ledsR, 4'b0110);
      chk4("full_ledsG", a_ledsG, 4'b0000);
      tick;
      chk1("full_done_pulse", a_done, 1'b0);
      chk4("full_hold_coil", a_coil, 4'b0110);

      // wave forward from idx 0, 2 steps, period 1
      a_start = 1'b1; a_steps = 16'd2; a_dir = 1'b1; a_mode = 2'b01; a_period = 16'd1;
      tick;
      a_start = 1'b0;
      chk4("wave_coil0", a_coil, 4'b0110);
      tick;
      chk4("wave_coil_wait", a_coil, 4'b0110);
      tick;
      chk4 ("wave_coil1", a_coil, 4'b0100);
      chk16("wave_pos1", a_pos, 16'd5);
      tick;
      tick;
      chk4 ("wave_coil2", a_coil, 4'b0001);
      chk16("wave_pos2", a_pos, 16'd6);
      chk1 ("wave_done", a_done, 1'b1);
      tick;

      // asynchronous reset takes effect without a clock edge
      #3;
      a_rst_n = 1'b0;
      #1;
      chk4 ("arst_coil", a_coil, 4'b0000);
      chk4 ("arst_ledsR", a_ledsR, 4'b0000);
      chk16("arst_pos", a_pos, 16'h0000);
      tick;
      a_rst_n = 1'b1;

      // half step reverse from idx 0, 3 steps, period 0
      a_start = 1'b1; a_steps = 16'd3; a_dir = 1'b0; a_mode = 2'b10; a_period = 16'd0;
      tick;
      a_start = 1'b0;
      chk4("half_coil0", a_coil, 4'b0110);
      chk4("half_ledsG0", a_ledsG, 4'b0110);
      chk4("half_ledsR0", a_ledsR, 4'b0000);
      tick;
      chk4 ("half_coil1", a_coil, 4'b0010);
      chk16("half_pos1", a_pos, 16'hFFFF);
      chk4 ("half_ledsG1", a_ledsG, 4'b0010);
      chk4 ("half_ledsR1", a_ledsR, 4'b0000);
      tick;
      chk4 ("half_coil2", a_coil, 4'b1010);
      chk16("half_pos2", a_pos, 16'hFFFE);
      tick;
      chk4 ("half_coil3", a_coil, 4'b1000);
      chk16("half_pos3", a_pos, 16'hFFFD);
      chk1 ("half_done", a_done, 1'b1);
      tick;

      // continuous run, reserved mode (full) from idx 5, period 2, hold and stop
      a_start = 1'b1; a_steps = 16'd0; a_dir = 1'b1; a_mode = 2'b11; a_period = 16'd2;
      tick;
      a_start = 1'b0;
      repeat (3) tick;
      chk4 ("cont_coil1", a_coil, 4'b1010);
      chk16("cont_pos1", a_pos, 16'hFFFE);
      tick;
      a_hold = 1'b1;
      repeat (5) tick;
      a_hold = 1'b0;
      chk1("cont_busy_hold", a_busy, 1'b1);
      chk4("cont_coil_hold", a_coil, 4'b1010);
      tick;
      chk4("cont_coil_late", a_coil, 4'b1010);
      tick;
      chk4 ("cont_coil2", a_coil, 4'b0110);
      chk16("cont_pos2", a_pos, 16'hFFFF);
      chk4 ("cont_ledsR2", a_ledsR, 4'b0110);
      tick;
      tick;
      a_stop = 1'b1;
      tick;
      a_stop = 1'b0;
      chk4 ("stop_coil", a_coil, 4'b0110);
      chk16("stop_pos", a_pos, 16'hFFFF);
      chk1 ("stop_busy", a_busy, 1'b0);
      chk1 ("stop_done", a_done, 1'b1);
      tick;
      chk1("stop_done_pulse", a_done, 1'b0);

      // HOLD_EN=0: coils released after done; start held high through RUN/DONE is ignored
      b_start = 1'b1; b_steps = 16'd2; b_dir = 1'b1; b_mode = 2'b00; b_period = 16'd0;
      tick;
      chk4("b_coil0", b_coil, 4'b0110);
      chk1("b_busy0", b_busy, 1'b1);
      tick;
      chk4("b_coil1", b_coil, 4'b0101);
      chk4("b_pos1", b_pos, 4'd1);
      tick;
      chk1("b_done", b_done, 1'b1);
      chk4("b_coil_done", b_coil, 4'b0000);
      chk4("b_pos2", b_pos, 4'd2);
      chk4("b_ledsR_done", b_ledsR, 4'b0000);
      tick;
      chk1("b_busy_ign", b_busy, 1'b0);
      chk1("b_done_pulse", b_done, 1'b0);
      b_start = 1'b0;
      tick;
      chk4("b_coil_idle", b_coil, 4'b0000);
      chk1("b_busy_idle", b_busy, 1'b0);

      // reset mid-move
      b_start = 1'b1; b_steps = 16'd5; b_period = 16'd3; b_dir = 1'b1; b_mode = 2'b00;
      tick;
      b_start = 1'b0;
      repeat (4) tick;
      chk4("b_mid_pos", b_pos, 4'd3);
      #3;
      b_rst_n = 1'b0;
      #1;
      chk4("b_rst_coil", b_coil, 4'b0000);
      chk1("b_rst_busy", b_busy, 1'b0);
      chk4("b_rst_pos", b_pos, 4'd0);
      chk4("b_rst_ledsR", b_ledsR, 4'b0000);
      tick;
      chk1("b_rst_nodone", b_done, 1'b0);
      b_rst_n = 1'b1;

      // position wrap with 4-bit counter
      b_start = 1'b1; b_steps = 16'd9; b_dir = 1'b1; b_mode = 2'b10; b_period = 16'd0;
      tick;
      b_start = 1'b0;
      repeat (9) tick;
      chk4("wrap_pos9", b_pos, 4'b1001);
      chk1("wrap_done9", b_done, 1'b1);
      tick;
      b_start = 1'b1; b_steps = 16'd2; b_dir = 1'b0; b_mode = 2'b10; b_period = 16'd0;
      tick;
      b_start = 1'b0;
      repeat (2) tick;
      chk4("wrap_pos7", b_pos, 4'd7);
      chk1("wrap_done7", b_done, 1'b1);
      tick;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/stepper_seq_ctrl.md
# stepper_seq_ctrl

Parametrised unipolar stepper-motor sequencer, the successor to the single-speed four-phase motor controller in the motor-control labs. Supports full-step, wave and half-step drive, programmable step period, bounded moves of N steps or continuous runs, pause, abort and a signed position counter. It sits between the front-panel/command logic and the coil drivers; direction LEDs are driven from the same block.

## Interface
- `DIV_W`, 16: width of step-period divider and `period` input.
- `CNT_W`, 16: width of `steps_n` and the remaining-steps counter.
- `POS_W`, 16: width of the signed position counter.
- `HOLD_EN`, 1: 1 = coils keep last phase when idle; 0 = coils driven 4'b0000 when idle.

- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: move request; sampled only in IDLE.
- `steps_n` in CNT_W: number of steps to take; 0 = continuous.
- `dir` in 1: 1 = forward, 0 = reverse; latched on start.
- `mode` in 2: 00 full, 01 wave, 10 half, 11 reserved (treated as full); latched on start.
- `period` in DIV_W: step every period+1 clocks; latched on start.
- `hold` in 1: live pause; freezes divider while high.
- `stop` in 1: abort; sampled only in RUN.
- `coil` out 4: coil drive pattern.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse on move completion or abort.
- `position` out POS_W: signed accumulated step count.
- `ledsR` out 4 / `ledsG` out 4: coil copy for forward / reverse.

## Operation
- Phase table, index 0..7: 0110, 0100, 0101, 0001, 1001, 1000, 1010, 0010. Even indices = full-step set, odd = wave set.
- Step rule: half: idx ±1. Full: idx even -> ±2; idx odd -> ±1 (lands even). Wave: idx odd -> ±2; idx even -> ±1. Index arithmetic modulo 8 (7+1=0, 0-1=7).
- `position` +1 per forward step, -1 per reverse step, irrespective of mode; wraps modulo 2^POS_W.
- FSM states IDLE, RUN, DONE.
  - IDLE: `start`=1 -> latch dir/mode/period/steps_n, clear divider, remaining = steps_n -> RUN.
  - RUN: divider increments each cycle unless `hold`; when divider == period and not hold -> apply one step, divider = 0, remaining -= 1 (bounded moves only). Last bounded step -> DONE. `stop`=1 -> DONE with no step that cycle (stop beats tick). `start` ignored.
  - DONE: `done`=1 for exactly one cycle -> IDLE. `start` ignored.
- `coil` = table[idx] in RUN; in IDLE/DONE = table[idx] if HOLD_EN else 4'b0000.
- `ledsR` = coil, `ledsG` = 0 when latched dir=1; swapped when 0; both 0 in IDLE with HOLD_EN=0.
- Reserved mode 11 behaves as full-step.

## Timing
- Reset (async, immediate): state IDLE, idx 0, divider 0, remaining 0, position 0, busy 0, done 0, coil 4'b0000, ledsR/ledsG 0000 regardless of HOLD_EN.
- Start sampled at edge E0: busy=1 and coil=table[idx] after E0. First step after edge E0+period+1; step k after E0+k(period+1).
- Each `hold` cycle postpones all later steps by one clock; hold on tick cycle suppresses that tick.
- Last step edge: coil/position update, state -> DONE, busy=0, done=1 same cycle; IDLE next edge. Next start accepted the cycle after done.
- Stop sampled at edge Es: busy=0, done=1 after Es; position reflects only completed steps.
- Reset during RUN aborts without a done pulse.
- period=0: one step per clock.

## Test plan
- Reset, HOLD_EN=1, start steps_n=4 dir=1 mode=full period=3 -> coil 0101,1001,1010,0110 at 4-clock spacing; position=4; done one pulse; busy=0.
- Half-step reverse from idx 0, steps_n=3, period=0 -> coil 0010,1010,1000 on consecutive clocks; position=-3; ledsG=coil, ledsR=0.
- Wave after full move ending at idx 0, steps_n=2 fwd -> 0100 then 0001 (idx 1, 3).
- Continuous run (steps_n=0), hold high 5 clocks mid-period -> step gap grows by exactly 5; stop asserted on a tick cycle -> no step, done pulse, busy low.
- HOLD_EN=0: after done coil=0000; start during RUN/DONE ignored; rst_n low mid-move -> all outputs 0 immediately, no done.
- Position wrap: POS_W=4, 9 forward steps from 0 then 2 reverse -> position 9 (as 4'b1001 = -7) then 7.
